// File: rtl/memory_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the three-port memory arbiter.
package memory_arbiter_pkg;

  localparam int NUM_PORTS  = 3;
  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;
  localparam int PORT_DMA   = 2;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when the word address falls inside the window of 2**log2 words at base.
  function automatic logic in_window(input logic [ADDR_W-1:0] address,
                                     input logic [31:0]       base,
                                     input int                log2);
    logic [31:0] byte_addr;
    byte_addr = {address, 2'b00};
    return (byte_addr >> (log2 + 2)) == (base >> (log2 + 2));
  endfunction

  // Index of a one-hot port vector; an empty vector maps to the fetch port.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'(PORT_FETCH);
    case (oh)
      3'(1 << PORT_DATA): idx = 2'(PORT_DATA);
      3'(1 << PORT_DMA):  idx = 2'(PORT_DMA);
      default:            idx = 2'(PORT_FETCH);
    endcase
    return idx;
  endfunction

  // Round-robin successor: the port after idx, wrapping modulo NUM_PORTS.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'(PORT_DMA)) ? 2'(PORT_FETCH) : idx + 2'd1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible port at or after ptr.
module rr_picker
  import memory_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [1:0]           ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 valid
);

  logic [2*NUM_PORTS-1:0] doubled;
  logic [2*NUM_PORTS-1:0] spread;
  logic [NUM_PORTS-1:0]   rotated;
  logic [NUM_PORTS-1:0]   first;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  always_comb begin
    doubled = {eligible, eligible};
    rotated = 3'(doubled >> ptr);
    first   = rotated & (~rotated + 3'd1);
    spread  = {3'b000, first} << ptr;
    grant   = spread[NUM_PORTS-1:0] | spread[2*NUM_PORTS-1:NUM_PORTS];
    valid   = |eligible;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between three bus masters.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int          MEM_WORDS_LOG2 = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           we,
  input  logic [NUM_PORTS*ADDR_W-1:0]    address,
  input  logic [NUM_PORTS*DATA_W-1:0]    wdata,
  input  logic [NUM_PORTS*STRB_W-1:0]    strobes,
  output logic [NUM_PORTS-1:0]           ack,
  output logic                           err,
  output logic [DATA_W-1:0]              rdata,
  output logic                           mem_cs,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [DATA_W-1:0]              mem_data_in,
  output logic [STRB_W-1:0]              mem_data_strobes,
  input  logic [DATA_W-1:0]              mem_data_out
);

  state_t               state;
  logic [1:0]           ptr;
  logic [NUM_PORTS-1:0] port_p0;

  // Registered copy of the access currently presented to the memory.
  logic                 cs_p0;
  logic                 read_p0;
  logic                 write_p0;
  logic [ADDR_W-1:0]    addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic [STRB_W-1:0]    strb_p0;

  logic                 completing;
  logic [NUM_PORTS-1:0] done_mask;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_vld;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [STRB_W-1:0]    sel_strb;
  logic                 sel_inwin;

  // Every BUSY cycle ends with a completion; the finishing port sits out this round.
  always_comb begin
    completing = (state == BUSY);
    done_mask  = completing ? port_p0 : '0;
    eligible   = req & ~done_mask;
  end

  rr_picker u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .valid    (grant_vld)
  );

  // Select the winning port's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_we    = we[i];
        sel_addr  = address[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_strb  = strobes[i*STRB_W +: STRB_W];
      end
    end
    sel_inwin = in_window(sel_addr, MEM_BASE, MEM_WORDS_LOG2);
  end

  // Arbitration FSM: complete the current access, then grant the next winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 2'(PORT_FETCH);
      port_p0  <= '0;
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      cs_p0    <= 1'b0;
      read_p0  <= 1'b0;
      write_p0 <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      strb_p0  <= '0;
    end else begin
      // ---- completion stage: response for the access that was on the bus ----
      ack   <= done_mask;
      err   <= completing & ~cs_p0;
      rdata <= (completing & read_p0) ? mem_data_out : '0;

      // ---- grant stage: latch the next access, or leave the bus quiet ----
      if (grant_vld) begin
        state    <= BUSY;
        ptr      <= next_ptr(onehot_to_idx(grant));
        port_p0  <= grant;
        cs_p0    <= sel_inwin;
        read_p0  <= sel_inwin & ~sel_we;
        write_p0 <= sel_inwin & sel_we;
        addr_p0  <= sel_addr;
        wdata_p0 <= sel_wdata;
        strb_p0  <= sel_strb;
      end else begin
        state    <= IDLE;
        port_p0  <= '0;
        cs_p0    <= 1'b0;
        read_p0  <= 1'b0;
        write_p0 <= 1'b0;
        addr_p0  <= '0;
        wdata_p0 <= '0;
        strb_p0  <= '0;
      end
    end
  end

  // Reset also gates the bus directly so an abandoned write never reaches the
  // memory at the falling edge of the cycle in which reset is raised.
  assign mem_cs           = cs_p0 & ~reset;
  assign mem_read         = read_p0 & ~reset;
  assign mem_write        = write_p0 & ~reset;
  assign mem_address      = reset ? '0 : addr_p0;
  assign mem_data_in      = reset ? '0 : wdata_p0;
  assign mem_data_strobes = reset ? '0 : strb_p0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level shadow memory.
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_b, we_b;
  logic [89:0] addr_b;
  logic [95:0] wdata_b;
  logic [11:0] strb_b;
  logic [2:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_cs, mem_read, mem_write;
  logic [29:0] mem_address;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_data_strobes;
  logic [31:0] mem_data_out;

  logic [31:0] mem    [1024];
  logic [31:0] shadow [1024];
  logic        fill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  memory_arbiter #(.MEM_BASE(32'h0000_0000), .MEM_WORDS_LOG2(10)) dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req_b),
    .we               (we_b),
    .address          (addr_b),
    .wdata            (wdata_b),
    .strobes          (strb_b),
    .ack              (ack),
    .err              (err),
    .rdata            (rdata),
    .mem_cs           (mem_cs),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_strobes (mem_data_strobes),
    .mem_data_out     (mem_data_out)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 7) return 32'hAAAAAAAA;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: acts on the falling edge, byte-strobed writes.
  always @(negedge clock) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_data_out <= 32'h0;
    end else if (mem_cs) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_data_strobes[b]) mem[mem_address[9:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
      if (mem_read) mem_data_out <= mem[mem_address[9:0]];
    end
  end

  // Scoreboard: every ack is matched against the presenting port's request and the shadow memory.
  initial begin : scoreboard
    int          p;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        oow;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    forever begin
      @(posedge clock);
      #1;
      if (ack != 3'b000) begin
        check_eq("ack_onehot", 64'($onehot(ack)), 1);
        p = ack[2] ? 2 : (ack[1] ? 1 : 0);
        check_eq("ack_req_held", req_b[p], 1);
        a   = addr_b[p*30 +: 30];
        d   = wdata_b[p*32 +: 32];
        s   = strb_b[p*4 +: 4];
        oow = (a >= 30'd1024);
        check_eq("ack_err", err, oow);
        check_eq("ack_rdata", rdata, (!oow && !we_b[p]) ? shadow[a[9:0]] : 32'h0);
        if (!oow && we_b[p])
          for (int b = 0; b < 4; b++)
            if (s[b]) shadow[a[9:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
  end

  // Out-of-window addresses must never reach the memory.
  initial begin : cs_watch
    forever begin
      @(negedge clock);
      if (mem_cs) check_eq("cs_in_window", 64'(mem_address >> 10), 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic set_port(input int p, input logic w, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    we_b[p]             = w;
    addr_b[p*30 +: 30]  = a;
    wdata_b[p*32 +: 32] = d;
    strb_b[p*4 +: 4]    = s;
    req_b[p]            = 1'b1;
  endtask

  // Present one request, hold it until its ack, then release; lat counts edges waited.
  task automatic access(input int p, input logic w, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
    logic done;
    set_port(p, w, a, d, s);
    lat  = 0;
    rd   = 32'h0;
    er   = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(posedge clock);
      #2;
      lat++;
      if (ack[p]) begin
        rd   = rdata;
        er   = err;
        done = 1'b1;
      end else if (lat >= 50) begin
        check_eq("ack_timeout", ack[p], 1);
        done = 1'b1;
      end
    end
    req_b[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int count);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          gap;
    logic [29:0] a;
    for (int n = 0; n < count; n++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) step(gap);
      if ($urandom_range(0, 7) == 0) a = 30'h400 + 30'($urandom_range(0, 4000));
      else                           a = 30'($urandom_range(0, 1023));
      access(p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, er, lat);
      check_eq("rr_latency_bound", 64'(lat <= 4), 1);
    end
  endtask

  task automatic mem_vs_shadow(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== shadow[i]) nmis++;
    check_eq(tag, nmis, 0);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        found;

    reset = 1'b1; fill = 1'b1;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; strb_b = '0;
    step(2);
    fill = 1'b0;
    step(2);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_mem_ctrl", {mem_cs, mem_read, mem_write, mem_data_strobes}, 0);
    check_eq("rst_mem_addr", mem_address, 0);
    check_eq("rst_mem_wdata", mem_data_in, 0);
    reset = 1'b0;
    step(1);

    // Single read from port 1.
    set_port(1, 1'b0, 30'd5, 32'h0, 4'hF);
    step(1);
    check_eq("rd_busy_ctrl", {mem_cs, mem_read, mem_write}, 3'b110);
    check_eq("rd_busy_addr", mem_address, 5);
    check_eq("rd_busy_noack", ack, 0);
    step(1);
    check_eq("rd_ack", ack, 3'b010);
    check_eq("rd_data", rdata, 32'hDEADBEEF);
    check_eq("rd_err", err, 0);
    check_eq("rd_done_cs", mem_cs, 0);
    req_b[1] = 1'b0;
    step(1);
    check_eq("rd_no_regrant", ack, 0);
    check_eq("rd_no_regrant_cs", mem_cs, 0);

    // Byte write, then read back.
    access(2, 1'b1, 30'd7, 32'h11223344, 4'b0010, rd, er, lat);
    check_eq("bw_rdata_zero", rd, 0);
    check_eq("bw_err", er, 0);
    access(2, 1'b0, 30'd7, 32'h0, 4'hF, rd, er, lat);
    check_eq("bw_readback", rd, 32'hAAAA33AA);

    // Write with no strobes completes and changes nothing.
    access(1, 1'b1, 30'd8, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
    check_eq("zs_err", er, 0);
    access(1, 1'b0, 30'd8, 32'h0, 4'hF, rd, er, lat);
    check_eq("zs_readback", rd, init_val(8));

    // Out-of-window accesses.
    set_port(0, 1'b0, 30'h400, 32'h0, 4'hF);
    step(1);
    check_eq("oow_busy_ctrl", {mem_cs, mem_read, mem_write}, 0);
    step(1);
    check_eq("oow_ack", ack, 3'b001);
    check_eq("oow_err", err, 1);
    check_eq("oow_rdata", rdata, 0);
    req_b[0] = 1'b0;
    step(1);
    access(0, 1'b1, 30'h400, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check_eq("oow_wr_err", er, 1);
    access(1, 1'b1, 30'h2000_0005, 32'h0, 4'hF, rd, er, lat);
    check_eq("oow_hi_err", er, 1);
    mem_vs_shadow("oow_mem_intact");

    // Reset during the BUSY cycle of a port-1 write.
    set_port(1, 1'b1, 30'd9, 32'h0, 4'hF);
    step(1);
    check_eq("mid_busy_write", {mem_write, mem_address}, {1'b1, 30'd9});
    reset    = 1'b1;
    req_b[1] = 1'b0;
    step(1);
    check_eq("mid_no_ack", ack, 0);
    check_eq("mid_outputs", {err, mem_cs, mem_read, mem_write, mem_data_strobes}, 0);
    check_eq("mid_rdata", rdata, 0);
    check_eq("mid_word_intact", mem[9], init_val(9));
    set_port(0, 1'b0, 30'd100, 32'h0, 4'hF);
    set_port(1, 1'b0, 30'd101, 32'h0, 4'hF);
    set_port(2, 1'b0, 30'd102, 32'h0, 4'hF);
    reset = 1'b0;
    step(1);
    check_eq("post_rst_winner", mem_address, 100);
    step(1);
    check_eq("post_rst_ack0", ack, 3'b001);
    req_b[0] = 1'b0;
    step(1);
    check_eq("post_rst_ack1", ack, 3'b010);
    req_b[1] = 1'b0;
    step(1);
    check_eq("post_rst_ack2", ack, 3'b100);
    req_b[2] = 1'b0;
    step(1);

    // Contention from reset: all ports request continuously.
    reset = 1'b1;
    step(2);
    fork
      begin
        logic [31:0] r0; logic e0; int l0;
        access(0, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r0, e0, l0);
        access(0, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r0, e0, l0);
      end
      begin
        logic [31:0] r1; logic e1; int l1;
        access(1, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r1, e1, l1);
        access(1, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r1, e1, l1);
      end
      begin
        logic [31:0] r2; logic e2; int l2;
        access(2, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r2, e2, l2);
        access(2, 1'b0, 30'($urandom_range(0, 1023)), 32'h0, 4'hF, r2, e2, l2);
      end
      begin
        step(1);
        reset = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
          step(1);
          if (ack != 3'b000) found = 1'b1;
        end
        check_eq("cont_started", found, 1);
        for (int k = 0; k < 6; k++) begin
          check_eq("cont_order", ack, 64'(1 << (k % 3)));
          if (k < 5) step(1);
        end
      end
    join
    step(1);

    // One port streaming alone: one access every second cycle.
    for (int k = 0; k < 4; k++) begin
      access(0, 1'b0, 30'(20 + k), 32'h0, 4'hF, rd, er, lat);
      check_eq("stream_spacing", lat, 2);
      check_eq("stream_data", rd, init_val(20 + k));
    end

    // Randomized traffic on all ports.
    fork
      rand_port(0, 40);
      rand_port(1, 40);
      rand_port(2, 40);
    join
    step(2);
    mem_vs_shadow("final_mem_match");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
